// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Produces {remainder, quotient}, one quotient bit per cycle, and stalls the pipeline until done.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               go;

  // Two's-complement negate when requested; wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  assign go         = start_i & ~annul_i;
  assign stallreq_o = start_i & ~annul_i & ~ready_q;
  assign result_o   = result_q;
  assign ready_o    = ready_q;

  // Trial subtract is WIDTH+1 bits; a set MSB means the divisor did not fit.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvsr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FREE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE:   if (go) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = S_END;
      S_ON:     if (annul_i) state_d = S_FREE;
                else if (cnt_q == CNT_LAST) state_d = S_END;
      S_END:    if (annul_i || !start_i) state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (go && opdata2_i != '0) begin
          // Magnitudes and signs are captured once; operand changes afterwards are ignored.
          rem_d  = '0;
          quo_d  = neg_if(opdata1_i, signed_i & opdata1_i[WIDTH-1]);
          dvsr_d = neg_if(opdata2_i, signed_i & opdata2_i[WIDTH-1]);
          negq_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d = signed_i & opdata1_i[WIDTH-1];
          cnt_d  = '0;
        end
      end
      S_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          result_d = {neg_if(rem_q, negr_q), neg_if(quo_q, negq_q)};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: drivers push expected {rem, quo} and ready cycle; a monitor checks on ready.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i, annul_i, signed_i;
  logic [WIDTH-1:0]   opdata1_i, opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o, stallreq_o;

  typedef struct {
    logic [2*WIDTH-1:0] res;
    int                 cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic ready_prev = 1'b0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expected entry.
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result_o, e.res);
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        check("stall_at_ready", 64'(stallreq_o), 64'd0);
      end
    end
    ready_prev = ready_o;
  end

  task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn,
                        input logic [WIDTH-1:0] exp_rem, input logic [WIDTH-1:0] exp_quo,
                        input logic rst_in_end);
    exp_t e;
    int   waited;
    bit   zero;
    zero = (b == '0);
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    @(posedge clk); #1;
    e.res = {exp_rem, exp_quo};
    e.cyc = cyc + (zero ? 1 : WIDTH + 1);
    sb_q.push_back(e);
    if (!zero) begin
      opdata1_i = ~a; opdata2_i = 32'h0000_0003;
    end
    waited = 0;
    @(negedge clk);
    while (!ready_o && waited < WIDTH + 8) begin
      check("stall_while_busy", 64'(stallreq_o), 64'd1);
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      check("ready_timeout", 64'(ready_o), 64'd1);
      start_i = 1'b0;
      void'(sb_q.pop_front());
      repeat (2) @(negedge clk);
      return;
    end
    @(negedge clk);
    check("ready_held", 64'(ready_o), 64'd1);
    check("result_held", result_o, {exp_rem, exp_quo});
    if (rst_in_end) begin
      #2 rst = 1'b1;
      #1;
      check("async_rst_ready", 64'(ready_o), 64'd0);
      check("async_rst_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      start_i = 1'b0;
      @(negedge clk);
      check("ready_drop", 64'(ready_o), 64'd0);
      check("result_clear", result_o, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;

    do_div(32'd100,        32'd7,          1'b0, 32'd2,          32'd14,         1'b0);
    do_div(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0);
    do_div(32'd7,          32'hFFFF_FFFE,  1'b1, 32'h0000_0001,  32'hFFFF_FFFD,  1'b0);
    do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h0,          32'h8000_0000,  1'b0);
    do_div(32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0,          32'hFFFF_FFFF,  1'b0);
    do_div(32'hFFFF_FFF9,  32'd2,          1'b0, 32'd1,          32'h7FFF_FFFC,  1'b0);
    do_div(32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFF,  32'd3,          1'b0);
    do_div(32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFF2,  1'b0);
    do_div(32'd3,          32'd10,         1'b0, 32'd3,          32'd0,          1'b0);
    do_div(32'd5,          32'd0,          1'b0, 32'd0,          32'd0,          1'b0);
    do_div(32'h8000_0000,  32'd0,          1'b1, 32'd0,          32'd0,          1'b0);

    // Flush at step 10: no result may appear, and the unit must be reusable.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    #1 check("stall_annul", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_no_ready", 64'(ready_o), 64'd0);
    do_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);

    // Asynchronous reset mid-operation, then a clean division afterwards.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd6;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_mid_on_ready", 64'(ready_o), 64'd0);
    check("rst_mid_on_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b1);
    do_div(32'd50,  32'd6, 1'b1, 32'd2, 32'd8,  1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
